// File: rtl/sram_rmw_pkg.sv
// ----------------------------------------------------------------------------
// sram_rmw_pkg
// Shared types and default geometry for the element read-modify-write
// controller and the element merge helper.
//   - state_t : controller FSM states (IDLE, READ, WRITE)
//   - op_t    : request operation (OP_WR overwrite, OP_ACC accumulate)
//   - ELEMS   : elements per SRAM word for the default geometry
// Optional feature macro used by the controller: SRAM_RMW_FWD_EN.
// ----------------------------------------------------------------------------
package sram_rmw_pkg;

    localparam int DEF_WIDTH      = 32;
    localparam int DEF_DEPTH      = 64;
    localparam int DEF_LG_DEPTH   = 6;
    localparam int DEF_ELEM_WIDTH = 8;
    localparam int DEF_LG_ELEMS   = 2;

    localparam int ELEMS = DEF_WIDTH / DEF_ELEM_WIDTH;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } state_t;

    typedef enum logic {
        OP_WR  = 1'b0,
        OP_ACC = 1'b1
    } op_t;

endpackage

// File: rtl/sram_rmw_ctrl_if.sv
// ----------------------------------------------------------------------------
// sram_rmw_ctrl_if
// Request/response bundle between an element writer (master) and the
// read-modify-write controller (slave).
//   req_valid/req_ready : request handshake
//   req_addr            : SRAM word address
//   req_elem            : element index inside the word
//   req_data            : element value
//   req_acc             : 0 overwrite, 1 accumulate (wrapping add)
//   resp_valid          : pulse in the write-back cycle
//   resp_word           : merged word written in that cycle
// ----------------------------------------------------------------------------
interface sram_rmw_ctrl_if
    import sram_rmw_pkg::*;
#(
    parameter int LG_DEPTH   = DEF_LG_DEPTH,
    parameter int LG_ELEMS   = DEF_LG_ELEMS,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int WIDTH      = DEF_WIDTH
);

    logic                  req_valid;
    logic                  req_ready;
    logic [LG_DEPTH-1:0]   req_addr;
    logic [LG_ELEMS-1:0]   req_elem;
    logic [ELEM_WIDTH-1:0] req_data;
    logic                  req_acc;
    logic                  resp_valid;
    logic [WIDTH-1:0]      resp_word;

    modport master (
        output req_valid, req_addr, req_elem, req_data, req_acc,
        input  req_ready, resp_valid, resp_word
    );

    modport slave (
        input  req_valid, req_addr, req_elem, req_data, req_acc,
        output req_ready, resp_valid, resp_word
    );

endinterface

// File: rtl/sram_elem_merge.sv
// ----------------------------------------------------------------------------
// sram_elem_merge
// Combinational element merge for element-packed SRAM words. Element k lives
// in bits [k*ELEM_WIDTH +: ELEM_WIDTH]. The selected element is replaced by
// data (overwrite) or by old+data modulo 2^ELEM_WIDTH (accumulate); all other
// elements pass through unchanged.
//   old_word in  WIDTH       word read from SRAM
//   elem     in  LG_ELEMS    element index
//   data     in  ELEM_WIDTH  element value
//   acc      in  1           0 overwrite, 1 accumulate
//   merged   out WIDTH       resulting word
// ----------------------------------------------------------------------------
module sram_elem_merge
    import sram_rmw_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int LG_ELEMS   = DEF_LG_ELEMS
) (
    input  logic [WIDTH-1:0]      old_word,
    input  logic [LG_ELEMS-1:0]   elem,
    input  logic [ELEM_WIDTH-1:0] data,
    input  logic                  acc,
    output logic [WIDTH-1:0]      merged
);

    localparam int N_ELEMS = WIDTH / ELEM_WIDTH;

    // Accumulation intentionally wraps; the carry out is discarded.
    function automatic logic [ELEM_WIDTH-1:0] add_wrap(
        input logic [ELEM_WIDTH-1:0] a,
        input logic [ELEM_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    always_comb begin
        merged = old_word;
        for (int k = 0; k < N_ELEMS; k++) begin
            if (elem == LG_ELEMS'(k)) begin
                merged[k*ELEM_WIDTH +: ELEM_WIDTH] =
                    (op_t'(acc) == OP_ACC)
                        ? add_wrap(old_word[k*ELEM_WIDTH +: ELEM_WIDTH], data)
                        : data;
            end
        end
    end

endmodule

// File: rtl/sram_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// sram_rmw_ctrl
// Element-granular read-modify-write controller driving port 0 of the dual
// port sram wrapper. A request is accepted in IDLE, the containing word is
// read (READ), merged with the element and written back (WRITE).
//   clk        in   clock
//   rst_n      in   asynchronous active-low reset
//   bus        slave request/response bundle (sram_rmw_ctrl_if)
//   sram_addr  out  to sram io_addr_0
//   sram_we    out  to sram io_we_0
//   sram_din   out  to sram io_din_0
//   sram_dout  in   from sram io_dout_0, valid one cycle after the address
//
// Optional feature macro SRAM_RMW_FWD_EN: remembers the last written word and
// skips the READ for a request to the same address. Only sound because this
// controller is the sole writer of its address range on port 0.
//
// sram_din and resp_word are the merge of sram_dout, which only becomes valid
// during WRITE, so they are gated combinationally by the registered state
// (zero outside WRITE). Every other output comes straight from a flop.
// ----------------------------------------------------------------------------
module sram_rmw_ctrl
    import sram_rmw_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int LG_DEPTH   = DEF_LG_DEPTH,
    parameter int ELEM_WIDTH = DEF_ELEM_WIDTH,
    parameter int LG_ELEMS   = DEF_LG_ELEMS
) (
    input  logic                clk,
    input  logic                rst_n,
    sram_rmw_ctrl_if.slave      bus,
    output logic [LG_DEPTH-1:0] sram_addr,
    output logic                sram_we,
    output logic [WIDTH-1:0]    sram_din,
    input  logic [WIDTH-1:0]    sram_dout
);

    if ((WIDTH % ELEM_WIDTH) != 0 ||
        (1 << LG_ELEMS) != (WIDTH / ELEM_WIDTH) ||
        (1 << LG_DEPTH) != DEPTH) begin : g_bad_cfg
        $error("sram_rmw_ctrl: inconsistent WIDTH/ELEM_WIDTH/LG_ELEMS/DEPTH");
    end

    state_t                state_q,     state_d;
    logic [LG_DEPTH-1:0]   addr_q,      addr_d;
    logic [LG_ELEMS-1:0]   elem_q,      elem_d;
    logic [ELEM_WIDTH-1:0] data_q,      data_d;
    op_t                   acc_q,       acc_d;
    logic                  req_ready_q, req_ready_d;
    logic [LG_DEPTH-1:0]   sram_addr_q, sram_addr_d;
    logic                  sram_we_q,   sram_we_d;
    logic                  resp_vld_q,  resp_vld_d;

    logic [WIDTH-1:0]      old_word;
    logic [WIDTH-1:0]      merged;

`ifdef SRAM_RMW_FWD_EN
    logic                  fwd_q,       fwd_d;
    logic [LG_DEPTH-1:0]   last_addr_q, last_addr_d;
    logic [WIDTH-1:0]      last_word_q, last_word_d;
    logic                  last_vld_q,  last_vld_d;

    // On a forwarded request the last written word is the current contents.
    assign old_word = fwd_q ? last_word_q : sram_dout;
`else
    assign old_word = sram_dout;
`endif

    sram_elem_merge #(
        .WIDTH      (WIDTH),
        .ELEM_WIDTH (ELEM_WIDTH),
        .LG_ELEMS   (LG_ELEMS)
    ) u_merge (
        .old_word (old_word),
        .elem     (elem_q),
        .data     (data_q),
        .acc      (acc_q),
        .merged   (merged)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        elem_d      = elem_q;
        data_d      = data_q;
        acc_d       = acc_q;
        req_ready_d = req_ready_q;
        sram_addr_d = sram_addr_q;
        sram_we_d   = 1'b0;
        resp_vld_d  = 1'b0;
`ifdef SRAM_RMW_FWD_EN
        fwd_d       = fwd_q;
        last_addr_d = last_addr_q;
        last_word_d = last_word_q;
        last_vld_d  = last_vld_q;
`endif

        // Outputs are registered, so each branch sets the values the next
        // state must present.
        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (bus.req_valid && req_ready_q) begin
                    addr_d      = bus.req_addr;
                    elem_d      = bus.req_elem;
                    data_d      = bus.req_data;
                    acc_d       = op_t'(bus.req_acc);
                    req_ready_d = 1'b0;
                    sram_addr_d = bus.req_addr;
                    state_d     = READ;
`ifdef SRAM_RMW_FWD_EN
                    fwd_d = 1'b0;
                    if (last_vld_q && (bus.req_addr == last_addr_q)) begin
                        fwd_d      = 1'b1;
                        state_d    = WRITE;
                        sram_we_d  = 1'b1;
                        resp_vld_d = 1'b1;
                    end
`endif
                end
            end

            // Address is on the SRAM this cycle; old word arrives in WRITE.
            READ: begin
                state_d     = WRITE;
                req_ready_d = 1'b0;
                sram_addr_d = addr_q;
                sram_we_d   = 1'b1;
                resp_vld_d  = 1'b1;
            end

            // Write-back commits at the end of this cycle.
            WRITE: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
`ifdef SRAM_RMW_FWD_EN
                fwd_d       = 1'b0;
                last_addr_d = addr_q;
                last_word_d = merged;
                last_vld_d  = 1'b1;
`endif
            end

            default: begin
                state_d     = IDLE;
                req_ready_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            elem_q      <= '0;
            data_q      <= '0;
            acc_q       <= OP_WR;
            req_ready_q <= 1'b0;
            sram_addr_q <= '0;
            sram_we_q   <= 1'b0;
            resp_vld_q  <= 1'b0;
`ifdef SRAM_RMW_FWD_EN
            fwd_q       <= 1'b0;
            last_addr_q <= '0;
            last_word_q <= '0;
            last_vld_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            elem_q      <= elem_d;
            data_q      <= data_d;
            acc_q       <= acc_d;
            req_ready_q <= req_ready_d;
            sram_addr_q <= sram_addr_d;
            sram_we_q   <= sram_we_d;
            resp_vld_q  <= resp_vld_d;
`ifdef SRAM_RMW_FWD_EN
            fwd_q       <= fwd_d;
            last_addr_q <= last_addr_d;
            last_word_q <= last_word_d;
            last_vld_q  <= last_vld_d;
`endif
        end
    end

    assign bus.req_ready  = req_ready_q;
    assign bus.resp_valid = resp_vld_q;
    assign bus.resp_word  = (state_q == WRITE) ? merged : '0;
    assign sram_addr      = sram_addr_q;
    assign sram_we        = sram_we_q;
    assign sram_din       = (state_q == WRITE) ? merged : '0;

endmodule

// File: tb/tb_sram_rmw_ctrl.sv
// ----------------------------------------------------------------------------
// tb_sram_rmw_ctrl
// Bench for sram_rmw_ctrl with a synchronous-read SRAM model on port 0 and a
// reference memory that applies each accepted request with plain arithmetic.
// Honours SRAM_RMW_FWD_EN when defined for the build.
// ----------------------------------------------------------------------------
module tb_sram_rmw_ctrl;

`ifdef SRAM_RMW_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  sram_addr;
    logic        sram_we;
    logic [31:0] sram_din;
    logic [31:0] sram_dout;

    always #5 clk = ~clk;

    sram_rmw_ctrl_if #(.LG_DEPTH(6), .LG_ELEMS(2), .ELEM_WIDTH(8), .WIDTH(32)) bus ();

    sram_rmw_ctrl #(
        .WIDTH(32), .DEPTH(64), .LG_DEPTH(6), .ELEM_WIDTH(8), .LG_ELEMS(2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .sram_addr (sram_addr),
        .sram_we   (sram_we),
        .sram_din  (sram_din),
        .sram_dout (sram_dout)
    );

    // SRAM port 0: read-first, dout valid the cycle after the address.
    logic [31:0] mem [64];
    logic        pl_en = 1'b0;
    logic [5:0]  pl_a  = '0;
    logic [31:0] pl_d  = '0;

    always @(posedge clk) begin
        if (pl_en) mem[pl_a] <= pl_d;
        else if (sram_we) mem[sram_addr] <= sram_din;
        sram_dout <= mem[sram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    typedef struct {
        logic [5:0]  addr;
        logic [31:0] word;
        int          cyc;
    } exp_t;

    logic [31:0] ref_mem [64];
    exp_t        exp_q [$];
    bit          lw_vld = 1'b0;
    logic [5:0]  lw_addr = '0;
    logic [31:0] last_resp = '0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (!ok) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference: apply the request to the model memory and predict the
    // write-back word and the cycle in which it appears.
    task automatic model_accept(input logic [5:0] a, input logic [1:0] e,
                                input logic [7:0] d, input logic ac, input int edge_i);
        logic [31:0] w;
        logic [7:0]  s;
        bit          hit;
        exp_t        x;
        w   = ref_mem[a];
        s   = w[int'(e)*8 +: 8];
        s   = ac ? 8'(s + d) : d;
        w[int'(e)*8 +: 8] = s;
        ref_mem[a] = w;
        hit = FWD && lw_vld && (lw_addr == a);
        lw_vld  = 1'b1;
        lw_addr = a;
        x.addr = a;
        x.word = w;
        x.cyc  = hit ? edge_i : edge_i + 1;
        exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            if (bus.resp_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "resp_unexpected", 32'(bus.resp_word), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    last_resp = bus.resp_word;
                    chk(bus.resp_word == e.word, "resp_word", bus.resp_word, e.word);
                    chk(sram_din == e.word, "sram_din", sram_din, e.word);
                    chk(sram_addr == e.addr, "sram_addr", 32'(sram_addr), 32'(e.addr));
                    chk(sram_we == 1'b1, "sram_we_wr", 32'(sram_we), 32'd1);
                    chk(cyc == e.cyc, "latency", 32'(cyc), 32'(e.cyc));
                end
            end else begin
                chk(sram_we == 1'b0, "sram_we_idle", 32'(sram_we), 32'd0);
            end
        end
    end

    task automatic preload(input logic [5:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        ref_mem[a] = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Present a request and hold it until accepted; returns the accept edge.
    task automatic send(input logic [5:0] a, input logic [1:0] e, input logic [7:0] d,
                        input logic ac, input bit model, output int edge_o);
        int g;
        g = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_addr  = a;
        bus.req_elem  = e;
        bus.req_data  = d;
        bus.req_acc   = ac;
        while (!bus.req_ready && g < 20) begin
            @(negedge clk);
            g++;
        end
        if (!bus.req_ready) begin
            chk(1'b0, "accept_timeout", 32'(g), 32'd20);
            bus.req_valid = 1'b0;
            edge_o = -1;
            return;
        end
        edge_o = cyc + 1;
        if (model) model_accept(a, e, d, ac, edge_o);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_data  = 8'($urandom);
    endtask

    task automatic wait_idle();
        int g;
        g = 0;
        @(negedge clk);
        while ((!bus.req_ready || exp_q.size() != 0) && g < 20) begin
            @(negedge clk);
            g++;
        end
        chk(bus.req_ready && exp_q.size() == 0, "idle_timeout", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: actual=running required=finished");
        n_bad++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

    initial begin
        int e1, e2, g, n_acc;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_elem  = '0;
        bus.req_data  = '0;
        bus.req_acc   = 1'b0;

        for (int i = 0; i < 64; i++) preload(6'(i), $urandom);

        // Reset values
        #2;
        chk(bus.req_ready == 1'b0, "rst_req_ready", 32'(bus.req_ready), 32'd0);
        chk(sram_we == 1'b0, "rst_sram_we", 32'(sram_we), 32'd0);
        chk(sram_addr == 6'd0, "rst_sram_addr", 32'(sram_addr), 32'd0);
        chk(sram_din == 32'd0, "rst_sram_din", sram_din, 32'd0);
        chk(bus.resp_valid == 1'b0, "rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk(bus.resp_word == 32'd0, "rst_resp_word", bus.resp_word, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk(bus.req_ready == 1'b1, "ready_after_rst", 32'(bus.req_ready), 32'd1);
        chk_en = 1'b1;

        // Single overwrite, ready timing
        preload(6'd5, 32'h11223344);
        send(6'd5, 2'd2, 8'hAB, 1'b0, 1'b1, e1);
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 10) begin
            @(negedge clk);
            g++;
        end
        chk(cyc == e1 + 2, "ready_return", 32'(cyc), 32'(e1 + 2));
        chk(mem[5] == 32'h11AB3344, "mem5", mem[5], 32'h11AB3344);
        chk(last_resp == 32'h11AB3344, "resp5", last_resp, 32'h11AB3344);
        wait_idle();

        // Accumulate wrap
        preload(6'd7, 32'h000000F0);
        send(6'd7, 2'd0, 8'h20, 1'b1, 1'b1, e1);
        wait_idle();
        chk(mem[7] == 32'h00000010, "mem7_wrap", mem[7], 32'h00000010);

        // Back-to-back accumulates to one address
        preload(6'd3, 32'h0);
        send(6'd3, 2'd1, 8'h01, 1'b1, 1'b1, e1);
        send(6'd3, 2'd1, 8'h01, 1'b1, 1'b1, e2);
        chk((e2 - e1) == (FWD ? 2 : 3), "b2b_spacing", 32'(e2 - e1), FWD ? 32'd2 : 32'd3);
        wait_idle();
        chk(mem[3] == 32'h00000200, "mem3_b2b", mem[3], 32'h00000200);

        // Request held while busy with changing data
        preload(6'd9, 32'h0);
        send(6'd9, 2'd0, 8'h11, 1'b0, 1'b1, e1);
        bus.req_valid = 1'b1;
        bus.req_addr  = 6'd9;
        bus.req_elem  = 2'd3;
        bus.req_acc   = 1'b0;
        bus.req_data  = 8'h55;
        g = 0;
        @(negedge clk);
        while (!bus.req_ready && g < 10) begin
            bus.req_data = 8'($urandom);
            @(negedge clk);
            g++;
        end
        bus.req_data = 8'h77;
        model_accept(6'd9, 2'd3, 8'h77, 1'b0, cyc + 1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_idle();
        chk(mem[9] == 32'h77000011, "mem9_hold", mem[9], 32'h77000011);

        // Reset during WRITE
        preload(6'd12, 32'hCAFEF00D);
        send(6'd12, 2'd0, 8'hEE, 1'b0, 1'b1, e1);
        wait_idle();
        chk_en = 1'b0;
        send(6'd12, 2'd2, 8'h5A, 1'b1, 1'b0, e1);
        g = 0;
        while (!sram_we && g < 4) begin
            @(posedge clk);
            #1;
            g++;
        end
        chk(sram_we == 1'b1, "we_before_rst", 32'(sram_we), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk(sram_we == 1'b0, "we_async_clr", 32'(sram_we), 32'd0);
        chk(sram_din == 32'd0, "din_async_clr", sram_din, 32'd0);
        chk(bus.resp_valid == 1'b0, "resp_async_clr", 32'(bus.resp_valid), 32'd0);
        lw_vld = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1 chk(bus.req_ready == 1'b1, "ready_after_rst_w", 32'(bus.req_ready), 32'd1);
        chk(mem[12] == 32'hCAFEF0EE, "mem12_rst_w", mem[12], 32'hCAFEF0EE);

        // Reset during READ
        send(6'd12, 2'd1, 8'h33, 1'b0, 1'b0, e1);
        chk(sram_we == 1'b0, "we_in_read", 32'(sram_we), 32'd0);
        chk(sram_addr == 6'd12, "addr_in_read", 32'(sram_addr), 32'd12);
        #1 rst_n = 1'b0;
        #1;
        chk(sram_addr == 6'd0, "addr_async_clr", 32'(sram_addr), 32'd0);
        chk(bus.req_ready == 1'b0, "ready_in_rst", 32'(bus.req_ready), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk(mem[12] == 32'hCAFEF0EE, "mem12_rst_r", mem[12], 32'hCAFEF0EE);
        chk_en = 1'b1;

        // Same address after reset must read the array again
        send(6'd12, 2'd1, 8'h01, 1'b1, 1'b1, e1);
        wait_idle();
        chk(mem[12] == 32'hCAFEF1EE, "mem12_after_rst", mem[12], 32'hCAFEF1EE);

        // Randomised stream, fields change every cycle even while busy
        n_acc = 0;
        g = 0;
        while (n_acc < 10000 && g < 80000) begin
            @(negedge clk);
            g++;
            bus.req_valid = ($urandom_range(0, 4) != 0);
            bus.req_addr  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 3))
                                                         : 6'($urandom_range(0, 63));
            bus.req_elem  = 2'($urandom);
            bus.req_data  = 8'($urandom);
            bus.req_acc   = 1'($urandom);
            if (bus.req_valid && bus.req_ready) begin
                model_accept(bus.req_addr, bus.req_elem, bus.req_data, bus.req_acc, cyc + 1);
                n_acc++;
            end
        end
        chk(n_acc == 10000, "stream_count", 32'(n_acc), 32'd10000);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
        wait_idle();

        for (int i = 0; i < 64; i++) begin
            chk(mem[i] == ref_mem[i], $sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sram_rmw_ctrl.md
Name: sram_rmw_ctrl

Overview:
- Element-granular read-modify-write controller that drives one port of the team's dual-port `sram` wrapper.
- Accepts narrow element-write or element-accumulate requests. It reads the containing SRAM word, merges the element in, and writes the word back.
- Sits directly upstream of `sram` port 0 in the weight/activation storage path.
- Port 1 of `sram` is left to other consumers.

Parameters:
- WIDTH, 32, SRAM word width in bits.
- DEPTH, 64, SRAM word count.
- LG_DEPTH, 6, address width, log2(DEPTH).
- ELEM_WIDTH, 8, element width; WIDTH must be a multiple of ELEM_WIDTH.
- LG_ELEMS, 2, log2(WIDTH/ELEM_WIDTH), the element-select width.

Ports:
- clk  in  1  single clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  LG_DEPTH  word address.
- req_elem  in  LG_ELEMS  element index within the word; element k occupies bits [k*ELEM_WIDTH +: ELEM_WIDTH].
- req_data  in  ELEM_WIDTH  element data.
- req_acc  in  1  0 = overwrite element, 1 = add req_data to the stored element.
- resp_valid  out  1  one-cycle pulse when the write-back is issued.
- resp_word  out  WIDTH  merged word written during the resp_valid cycle.
- sram_addr  out  LG_DEPTH  to sram io_addr_0.
- sram_we  out  1  to sram io_we_0.
- sram_din  out  WIDTH  to sram io_din_0.
- sram_dout  in  WIDTH  from sram io_dout_0; valid one cycle after the address is presented.

Behaviour:
- All outputs and state are registered and cleared by rst_n low, asynchronously.
  - Reset values: req_ready=0 during reset and 1 in the first cycle after release; sram_we=0; sram_addr=0; sram_din=0; resp_valid=0; resp_word=0; state=IDLE.
- FSM states are IDLE, READ, WRITE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture addr, elem, data and acc, then go to READ.
- READ:
  - Drive sram_addr=captured addr, sram_we=0. req_ready=0.
  - Next state is WRITE.
- WRITE:
  - sram_dout holds the old word.
  - Merged word = old word with element elem replaced by data (acc=0), or by (old_elem + data) mod 2^ELEM_WIDTH (acc=1). Overflow wraps; other elements are unchanged.
  - Drive sram_addr=addr, sram_we=1, sram_din=merged; resp_valid=1, resp_word=merged.
  - Next state is IDLE.
- Timing:
  - Latency is accept cycle t, read at t+1, write at t+2.
  - Throughput is one request per 3 cycles.
  - req_ready returns high at t+3.
- Back-to-back requests to the same address are hazard-free: the write at t+2 commits before the next READ at t+4 or later.
- req_* inputs are ignored whenever req_ready=0; a request is held by the requester until accepted.
- Reset mid-operation:
  - Abandons the operation; no write is issued.
  - A reset asserted during WRITE deasserts sram_we immediately (async clear).
- req_elem is always in range because WIDTH/ELEM_WIDTH is a power of two (enforced at elaboration).

Optional Feature:
- Macro SRAM_RMW_FWD_EN.
- Defined:
  - Hold last_addr, last_word and last_vld, set on each WRITE and cleared by reset.
  - In IDLE, if the accepted req_addr==last_addr and last_vld=1, skip READ and go directly to WRITE using last_word as the old word.
  - Latency becomes 2 cycles, throughput one per 2 cycles for same-address streams.
  - Valid only because this controller is the sole writer of port 0's address range; port 1 writes to the same addresses are prohibited in this build.
- Undefined: always READ, 3-cycle operation, no forwarding registers.

Decomposition:
- Package sram_rmw_pkg:
  - state enum (IDLE, READ, WRITE).
  - localparam ELEMS = WIDTH/ELEM_WIDTH.
  - op encoding (OP_WR=0, OP_ACC=1).
- Sub-module sram_elem_merge: purely combinational; inputs old word, elem, data, acc; output merged word. Reused by other element-packed SRAM writers.

Test Plan:
- Reset, then one request: addr=5, elem=2, data=0xAB, acc=0, with mem[5]=0x11223344.
  - Expect sram_we at t+2, sram_din=0x11AB3344, resp_valid pulse, req_ready high at t+3.
- Accumulate wrap: mem[7]=0x000000F0; request elem=0, data=0x20, acc=1.
  - Expect written word 0x00000010 (wraps); other bytes untouched.
- Two back-to-back accumulates to addr 3, elem 1, data 0x01, starting from mem[3]=0.
  - Expect final word 0x00000200.
  - Cycle spacing: 3 cycles without SRAM_RMW_FWD_EN, 2 cycles with it.
- req_valid held high while busy with changing req_data.
  - Expect only the value present in the req_ready cycle to be captured.
- Assert rst_n low during READ and during WRITE.
  - Expect sram_we=0 immediately, memory unchanged, state IDLE.
  - With the macro defined, expect last_vld cleared so the next same-address request performs a READ.
- Randomised element writes against a reference memory model, 10k requests across all elem values.
  - Expect final memory contents to match the model exactly.
